// File: rtl/riscv32ima_pkg.sv
// rtl/riscv32ima_pkg.sv - shared widths and FSM state type for the data-memory responder
package riscv32ima_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int CNT_WIDTH      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/riscv32ima_dmem_ram.sv
// rtl/riscv32ima_dmem_ram.sv - single-port word array with keep-mask write merge and registered read
module riscv32ima_dmem_ram
  import riscv32ima_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  we,
  input  logic                  rd_clr,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] wmask,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // rd_clr covers reads that fall outside the window: they return zero
  always_comb begin
    rdata_d = rdata_q;
    if (rd_clr) begin
      rdata_d = '0;
    end else if (en && !we) begin
      rdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // A set mask bit keeps the stored bit; the array itself is never reset
  always_ff @(posedge clk) begin
    if (nrst && en && we) begin
      mem[idx] <= (mem[idx] & wmask) | (wdata & ~wmask);
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/riscv32ima_dmem.sv
// rtl/riscv32ima_dmem.sv - LSU data-memory responder with wait states and address window check
module riscv32ima_dmem
  import riscv32ima_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int                    DEPTH_LOG2  = 10,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  d_ncs,
  input  logic                  d_nwe,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [DATA_WIDTH-1:0] d_wmask,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_stall,
  output logic                  oor_err
);

  dmem_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  lat_nwe_q, lat_nwe_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_WIDTH-1:0] lat_wmask_q, lat_wmask_d;
  logic                  oor_q, oor_d;

  logic                  exec;
  logic                  ex_nwe;
  logic [ADDR_WIDTH-1:0] ex_addr;
  logic [DATA_WIDTH-1:0] ex_wdata;
  logic [DATA_WIDTH-1:0] ex_wmask;
  logic                  in_range;
  logic                  ram_en;
  logic                  ram_rd_clr;
  logic                  unused_addr_lsb;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_nwe_d   = lat_nwe_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_wmask_d = lat_wmask_q;
    exec        = 1'b0;
    ex_nwe      = d_nwe;
    ex_addr     = d_addr;
    ex_wdata    = d_wdata;
    ex_wmask    = d_wmask;

    case (state_q)
      IDLE: begin
        if (!d_ncs) begin
          if (WAIT_STATES == 0) begin
            exec = 1'b1;
          end else begin
            lat_nwe_d   = d_nwe;
            lat_addr_d  = d_addr;
            lat_wdata_d = d_wdata;
            lat_wmask_d = d_wmask;
            cnt_d       = CNT_WIDTH'(WAIT_STATES - 1);
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        // Only the request latched at the accept edge executes; live inputs are ignored here
        ex_nwe   = lat_nwe_q;
        ex_addr  = lat_addr_q;
        ex_wdata = lat_wdata_q;
        ex_wmask = lat_wmask_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          exec    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_range   = ex_addr[ADDR_WIDTH-1:DEPTH_LOG2+3] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2+3];
  assign ram_en     = nrst && exec && in_range;
  assign ram_rd_clr = exec && !in_range && ex_nwe;

  always_comb begin
    oor_d = oor_q;
    if (exec && !in_range) begin
      oor_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_nwe_q   <= 1'b1;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_wmask_q <= '1;
      oor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_nwe_q   <= lat_nwe_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_wmask_q <= lat_wmask_d;
      oor_q       <= oor_d;
    end
  end

  riscv32ima_dmem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .nrst  (nrst),
    .en    (ram_en),
    .we    (!ex_nwe),
    .rd_clr(ram_rd_clr),
    .idx   (ex_addr[DEPTH_LOG2+2:3]),
    .wdata (ex_wdata),
    .wmask (ex_wmask),
    .rdata (d_rdata)
  );

  assign unused_addr_lsb = ^ex_addr[2:0];
  assign d_stall         = (state_q == IDLE);
  assign oor_err         = oor_q;

endmodule

// File: tb/tb_riscv32ima_dmem.sv
// tb/tb_riscv32ima_dmem.sv - self-checking bench for riscv32ima_dmem across wait-state and window settings
module tb_riscv32ima_dmem;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ncs [4];
  logic        nwe;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [63:0] wmask;
  logic [63:0] rdata [4];
  logic        stall [4];
  logic        oor [4];

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  riscv32ima_dmem #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .nrst(nrst), .d_ncs(ncs[0]), .d_nwe(nwe), .d_addr(addr), .d_wdata(wdata),
    .d_wmask(wmask), .d_rdata(rdata[0]), .d_stall(stall[0]), .oor_err(oor[0]));
  riscv32ima_dmem #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .nrst(nrst), .d_ncs(ncs[1]), .d_nwe(nwe), .d_addr(addr), .d_wdata(wdata),
    .d_wmask(wmask), .d_rdata(rdata[1]), .d_stall(stall[1]), .oor_err(oor[1]));
  riscv32ima_dmem #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .nrst(nrst), .d_ncs(ncs[2]), .d_nwe(nwe), .d_addr(addr), .d_wdata(wdata),
    .d_wmask(wmask), .d_rdata(rdata[2]), .d_stall(stall[2]), .oor_err(oor[2]));
  riscv32ima_dmem #(.WAIT_STATES(0), .BASE_ADDR(32'h8000_0000)) u_oor (
    .clk(clk), .nrst(nrst), .d_ncs(ncs[3]), .d_nwe(nwe), .d_addr(addr), .d_wdata(wdata),
    .d_wmask(wmask), .d_rdata(rdata[3]), .d_stall(stall[3]), .oor_err(oor[3]));

  function automatic int ws_of(input int k);
    case (k)
      1:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  // One request on instance k; reads push their expected word and pop it when d_stall returns high
  task automatic access(input int k, input bit wr, input logic [31:0] a, input logic [63:0] wd,
                        input logic [63:0] wm, input logic [63:0] exp_rd, input string nm);
    int n;
    int lat;
    logic [63:0] e;
    @(negedge clk);
    n = 0;
    while (!stall[k] && n < 100) begin @(negedge clk); n++; end
    ncs[k] = 1'b0; nwe = !wr; addr = a; wdata = wd; wmask = wm;
    if (!wr) exp_q.push_back(exp_rd);
    @(posedge clk);
    @(negedge clk);
    ncs[k] = 1'b1;
    lat = 1; n = 0;
    while (!stall[k] && n < 100) begin @(negedge clk); n++; lat++; end
    tests++;
    if (lat != ws_of(k) + 1) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", nm, lat, ws_of(k) + 1);
    end
    if (!wr) begin
      e = exp_q.pop_front();
      tests++;
      if (rdata[k] !== e) begin
        fails++;
        $display("FAIL %s_rdata: got %h, expected %h", nm, rdata[k], e);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nrst = 1'b0; ncs[0] = 1'b0; nwe = 1'b0; addr = 32'h40; wdata = 64'hDEAD_DEAD_DEAD_DEAD; wmask = '0;
    repeat (3) @(negedge clk);
    nrst = 1'b1; ncs[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (stall[k] !== 1'b1) begin fails++; $display("FAIL reset_stall[%0d]: got %b, expected 1", k, stall[k]); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (rdata[k] !== 64'h0 || oor[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: rdata %h oor %b, expected 0 and 0", k, rdata[k], oor[k]);
      end
    end
    access(0, 0, 32'h40, '0, '1, 64'hCAFE_F00D_1234_5678, "reset_no_write");
  endtask

  task automatic test_byte_store();
    access(0, 1, 32'h10, 64'h1122_3344_5566_7788, '0, '0, "byte_preset");
    access(0, 1, 32'h13, {8{8'hAB}}, 64'hFFFF_FFFF_FFFF_00FF, '0, "byte_store");
    access(0, 0, 32'h10, '0, '1, 64'h1122_3344_5566_AB88, "byte_read");
    access(0, 1, 32'h10, 64'h0, '1, '0, "allones_noop");
    access(0, 0, 32'h10, '0, '1, 64'h1122_3344_5566_AB88, "noop_read");
  endtask

  task automatic test_wait_states();
    logic [63:0] e;
    logic        st1, st2;
    access(1, 1, 32'h18, 64'h0F0E_0D0C_0B0A_0908, '0, '0, "ws2_preset");
    @(negedge clk);
    ncs[1] = 1'b0; nwe = 1'b1; addr = 32'h18;
    exp_q.push_back(64'h0F0E_0D0C_0B0A_0908);
    @(posedge clk);
    // A competing write while busy must be neither queued nor allowed to disturb the latched read
    @(negedge clk);
    st1 = stall[1]; nwe = 1'b0; wdata = '1; wmask = '0; addr = 32'h18;
    @(negedge clk);
    st2 = stall[1]; ncs[1] = 1'b1; nwe = 1'b1;
    @(negedge clk);
    tests++;
    if (st1 !== 1'b0 || st2 !== 1'b0 || stall[1] !== 1'b1) begin
      fails++;
      $display("FAIL ws2_stall_shape: got %b%b%b, expected 001", st1, st2, stall[1]);
    end
    e = exp_q.pop_front();
    tests++;
    if (rdata[1] !== e) begin fails++; $display("FAIL ws2_read: got %h, expected %h", rdata[1], e); end
    access(1, 0, 32'h18, '0, '1, 64'h0F0E_0D0C_0B0A_0908, "ws2_ignored_write");
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    access(0, 1, 32'h20, 64'h0123_4567_89AB_CDEF, '0, '0, "b2b_preset");
    @(negedge clk);
    ncs[0] = 1'b0; nwe = 1'b0; addr = 32'h26; wdata = {4{16'hBEEF}}; wmask = 64'hFFFF_0000_FFFF_FFFF;
    @(negedge clk);
    nwe = 1'b1; addr = 32'h20;
    exp_q.push_back(64'h0123_BEEF_89AB_CDEF);
    @(negedge clk);
    ncs[0] = 1'b1;
    e = exp_q.pop_front();
    tests++;
    if (rdata[0] !== e) begin fails++; $display("FAIL b2b_read: got %h, expected %h", rdata[0], e); end
  endtask

  task automatic test_out_of_range();
    access(3, 1, 32'h8000_0008, 64'h5555_AAAA_5555_AAAA, '0, '0, "oor_preset");
    tests++;
    if (oor[3] !== 1'b0) begin fails++; $display("FAIL oor_inrange_flag: got %b, expected 0", oor[3]); end
    access(3, 1, 32'h0000_0008, 64'h1111_2222_3333_4444, '0, '0, "oor_write");
    tests++;
    if (oor[3] !== 1'b1) begin fails++; $display("FAIL oor_flag_set: got %b, expected 1", oor[3]); end
    access(3, 0, 32'h8000_0008, '0, '1, 64'h5555_AAAA_5555_AAAA, "oor_prime");
    access(3, 0, 32'h0000_0008, '0, '1, 64'h0, "oor_read");
    access(3, 0, 32'h8000_0008, '0, '1, 64'h5555_AAAA_5555_AAAA, "oor_array_kept");
    tests++;
    if (oor[3] !== 1'b1) begin fails++; $display("FAIL oor_sticky: got %b, expected 1", oor[3]); end
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
    tests++;
    if (oor[3] !== 1'b0) begin fails++; $display("FAIL oor_cleared: got %b, expected 0", oor[3]); end
  endtask

  task automatic test_reset_mid_wait();
    access(2, 1, 32'h30, 64'hA5A5_0000_5A5A_FFFF, '0, '0, "ws3_preset");
    access(2, 0, 32'h30, '0, '1, 64'hA5A5_0000_5A5A_FFFF, "ws3_read");
    @(negedge clk);
    ncs[2] = 1'b0; nwe = 1'b0; addr = 32'h30; wdata = 64'h0; wmask = '0;
    @(negedge clk);
    ncs[2] = 1'b1;
    tests++;
    if (stall[2] !== 1'b0) begin fails++; $display("FAIL ws3_busy: got %b, expected 0", stall[2]); end
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    tests++;
    if (stall[2] !== 1'b1 || rdata[2] !== 64'h0) begin
      fails++;
      $display("FAIL ws3_after_reset: stall %b rdata %h, expected 1 and 0", stall[2], rdata[2]);
    end
    access(2, 0, 32'h30, '0, '1, 64'hA5A5_0000_5A5A_FFFF, "ws3_discarded");
  endtask

  initial begin
    for (int k = 0; k < 4; k++) ncs[k] = 1'b1;
    nrst = 1'b0; nwe = 1'b1; addr = '0; wdata = '0; wmask = '1;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    access(0, 1, 32'h40, 64'hCAFE_F00D_1234_5678, '0, '0, "init_preset");
    test_reset();
    test_byte_store();
    test_wait_states();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
